// File: rtl/demux_1to4_stream_pkg.sv
// rtl/demux_1to4_stream_pkg.sv - shared constants and lane-state type for the 1:4 stream demux
package demux_pkg;

    localparam int DEMUX_WIDTH   = 32;
    localparam int DEMUX_NUM_OUT = 4;
    localparam int DEMUX_SEL_W   = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_1to4_stream_if.sv
// rtl/demux_1to4_stream_if.sv - producer/consumer bundle for the demux; out_cnt exists only with DEMUX_COUNT_EN
interface demux_1to4_stream_if
    import demux_pkg::*;
#(
    parameter int WIDTH   = DEMUX_WIDTH,
    parameter int NUM_OUT = DEMUX_NUM_OUT
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W   = 16
`endif
);

    logic                     in_valid;
    logic                     in_ready;
    logic [DEMUX_SEL_W-1:0]   in_sel;
    logic [WIDTH-1:0]         in_data;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [NUM_OUT*WIDTH-1:0] out_data;
`ifdef DEMUX_COUNT_EN
    logic [NUM_OUT*CNT_W-1:0] out_cnt;
`endif

    // slave is the demux side; master is the bench/system side driving it
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
`ifdef DEMUX_COUNT_EN
        ,
        output out_cnt
`endif
    );

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
`ifdef DEMUX_COUNT_EN
        ,
        input  out_cnt
`endif
    );

endinterface

// File: rtl/demux_1to4_stream_slot.sv
// rtl/demux_1to4_stream_slot.sv - one-entry output lane buffer; pop counter under DEMUX_COUNT_EN
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             ready,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic [WIDTH-1:0] dout
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    slot_state_t      state, state_nxt;
    logic [WIDTH-1:0] data_q;
    logic             pop;

    assign pop = full & ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SLOT_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_EMPTY: if (push)         state_nxt = SLOT_FULL;
            SLOT_FULL:  if (pop && !push) state_nxt = SLOT_EMPTY;
            default:                      state_nxt = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        full = (state == SLOT_FULL);
        dout = data_q;
    end

    // a push while full is only allowed alongside a pop, so reloading here never drops a word
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       data_q <= '0;
        else if (push) data_q <= din;
    end

`ifdef DEMUX_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (pop) cnt <= cnt + 1'b1;
    end
`endif

endmodule

// File: rtl/demux_1to4_stream.sv
// rtl/demux_1to4_stream.sv - 1:4 stream demux top: select decode and in_ready steering (DEMUX_COUNT_EN adds lane counters)
module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH   = DEMUX_WIDTH,
    parameter int NUM_OUT = DEMUX_NUM_OUT
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_1to4_stream_if.slave   bus
);

    logic [NUM_OUT-1:0] full;
    logic [NUM_OUT-1:0] push;
    logic               push_any;
    logic [WIDTH-1:0]   lane_data [NUM_OUT];
`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0]   lane_cnt  [NUM_OUT];
`endif

    // ready depends only on the addressed lane, so a stalled lane never blocks the others
    assign bus.in_ready  = !full[bus.in_sel] | bus.out_ready[bus.in_sel];
    assign push_any      = bus.in_valid & bus.in_ready;
    assign bus.out_valid = full;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
        assign push[i] = push_any & (bus.in_sel == DEMUX_SEL_W'(i));

        demux_slot #(
            .WIDTH (WIDTH)
`ifdef DEMUX_COUNT_EN
            ,
            .CNT_W (CNT_W)
`endif
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .ready (bus.out_ready[i]),
            .din   (bus.in_data),
            .full  (full[i]),
            .dout  (lane_data[i])
`ifdef DEMUX_COUNT_EN
            ,
            .cnt   (lane_cnt[i])
`endif
        );

        assign bus.out_data[i*WIDTH +: WIDTH] = lane_data[i];
`ifdef DEMUX_COUNT_EN
        assign bus.out_cnt[i*CNT_W +: CNT_W]  = lane_cnt[i];
`endif
    end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// tb/tb_demux_1to4_stream.sv - directed self-checking bench for demux_1to4_stream (counter checks with DEMUX_COUNT_EN)
module tb_demux_1to4_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    demux_1to4_stream_if #(
        .WIDTH   (32),
        .NUM_OUT (4)
`ifdef DEMUX_COUNT_EN
        ,
        .CNT_W   (4)
`endif
    ) bus ();

    demux_1to4_stream #(
        .WIDTH   (32),
        .NUM_OUT (4)
`ifdef DEMUX_COUNT_EN
        ,
        .CNT_W   (4)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] lane(input int i);
        return bus.out_data[i*32 +: 32];
    endfunction

`ifdef DEMUX_COUNT_EN
    function automatic logic [3:0] lane_cnt(input int i);
        return bus.out_cnt[i*4 +: 4];
    endfunction
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] words [4];

    initial begin
        words[0] = 32'hA0A0_0000;
        words[1] = 32'hB1B1_0001;
        words[2] = 32'hC2C2_0002;
        words[3] = 32'hD3D3_0003;

        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 4'h0;

        // reset state
        #1;
        chk("reset_valid", 64'(bus.out_valid), 64'h0);
        chk("reset_data", 64'(bus.out_data), 64'h0);
`ifdef DEMUX_COUNT_EN
        chk("reset_cnt", 64'(bus.out_cnt), 64'h0);
`endif
        step();
        step();
        rst = 1'b0;

        // basic routing, one word per lane
        bus.out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'(i);
            bus.in_data  = words[i];
            #1;
            chk($sformatf("route_in_ready_%0d", i), 64'(bus.in_ready), 64'h1);
            step();
            chk($sformatf("route_valid_%0d", i), 64'(bus.out_valid), 64'(4'b0001 << i));
            chk($sformatf("route_data_%0d", i), 64'(lane(i)), 64'(words[i]));
        end
        bus.in_valid = 1'b0;
        step();
        chk("route_drained", 64'(bus.out_valid), 64'h0);

        // backpressure isolation on lane 2
        bus.out_ready = 4'b1011;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd2;
        bus.in_data   = 32'h1;
        step();
        chk("bp_lane2_valid", 64'(bus.out_valid), 64'h4);
        chk("bp_lane2_data1", 64'(lane(2)), 64'h1);
        bus.in_data = 32'h2;
        #1;
        chk("bp_in_ready_blocked", 64'(bus.in_ready), 64'h0);
        step();
        chk("bp_lane2_held", 64'(lane(2)), 64'h1);
        chk("bp_lane0_empty", 64'(bus.out_valid), 64'h4);
        chk("bp_still_blocked", 64'(bus.in_ready), 64'h0);
        bus.in_sel = 2'd0;
        #1;
        chk("bp_other_lane_ready", 64'(bus.in_ready), 64'h1);
        bus.in_sel = 2'd2;
        bus.out_ready = 4'b1111;
        #1;
        chk("bp_released_ready", 64'(bus.in_ready), 64'h1);
        step();
        chk("bp_lane2_data2", 64'(lane(2)), 64'h2);
        chk("bp_lane2_valid2", 64'(bus.out_valid), 64'h4);
        bus.in_sel  = 2'd0;
        bus.in_data = 32'h3;
        step();
        chk("bp_word3_lane0", 64'(bus.out_valid), 64'h1);
        chk("bp_word3_data", 64'(lane(0)), 64'h3);
        bus.in_valid = 1'b0;
        step();
        chk("bp_drained", 64'(bus.out_valid), 64'h0);

        // same-cycle pop and push on lane 1
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_data   = 32'h11;
        step();
        chk("pp_lane1_full", 64'(bus.out_valid), 64'h2);
        chk("pp_lane1_data11", 64'(lane(1)), 64'h11);
        bus.out_ready = 4'b0010;
        bus.in_data   = 32'h22;
        #1;
        chk("pp_in_ready", 64'(bus.in_ready), 64'h1);
        step();
        chk("pp_no_bubble", 64'(bus.out_valid), 64'h2);
        chk("pp_lane1_data22", 64'(lane(1)), 64'h22);
        bus.in_valid = 1'b0;
        step();
        chk("pp_drained", 64'(bus.out_valid), 64'h0);

        // asynchronous reset with lanes 0 and 3 full
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 32'hAAAA_0000;
        step();
        bus.in_sel  = 2'd3;
        bus.in_data = 32'h3333_0003;
        step();
        bus.in_valid = 1'b0;
        chk("ar_pre_valid", 64'(bus.out_valid), 64'h9);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_async_valid", 64'(bus.out_valid), 64'h0);
        chk("ar_async_data", 64'(bus.out_data), 64'h0);
        step();
        rst = 1'b0;
        bus.out_ready = 4'hF;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = words[0];
        #1;
        chk("ar_post_ready", 64'(bus.in_ready), 64'h1);
        step();
        chk("ar_post_valid", 64'(bus.out_valid), 64'h1);
        chk("ar_post_data", 64'(lane(0)), 64'(words[0]));
        bus.in_valid = 1'b0;
        step();

        // data hold while lane 0 stalls and the input wiggles with in_valid low
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 32'h5555_AAAA;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = $urandom;
            step();
            chk($sformatf("hold_valid_%0d", i), 64'(bus.out_valid), 64'h1);
            chk($sformatf("hold_data_%0d", i), 64'(lane(0)), 64'h5555_AAAA);
        end
        chk("hold_in_ready_idle", 64'(bus.in_ready), 64'h0);

`ifdef DEMUX_COUNT_EN
        // counter wrap: 17 pops on lane 3 with a 4-bit counter
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("cnt_after_reset", 64'(bus.out_cnt), 64'h0);
        bus.out_ready = 4'hF;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd3;
        for (int i = 0; i < 17; i++) begin
            bus.in_data = 32'(i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        chk("cnt_lane3_wrap", 64'(lane_cnt(3)), 64'h1);
        chk("cnt_lane0", 64'(lane_cnt(0)), 64'h0);
        chk("cnt_lane1", 64'(lane_cnt(1)), 64'h0);
        chk("cnt_lane2", 64'(lane_cnt(2)), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1to4_stream.md
Name: demux_1to4_stream

Overview:
- Inverse of the team's 4:1 case mux: steers one 32-bit input stream to one of four output streams, chosen by a 2-bit select that travels with the data.
- Each output has a one-entry registered slot with a valid/ready handshake, so a stalled consumer blocks only its own lane.
- Sits between a single producer and four independent consumers, for example fanning a bus out to four units.

Parameters:
- WIDTH, 32, data width of the input and of each output lane.
- NUM_OUT, 4, number of output lanes. Fixed at 4 for this revision; the select is 2 bits wide.
- CNT_W, 16, width of each per-lane transfer counter. Used only when DEMUX_COUNT_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block can accept the word this cycle.
- in_sel  input  2  destination lane: 2'b00 = lane 0, 2'b01 = lane 1, 2'b10 = lane 2, 2'b11 = lane 3.
- in_data  input  WIDTH  payload.
- out_valid  output  NUM_OUT  bit i set means lane i holds a word.
- out_ready  input  NUM_OUT  bit i set means consumer i accepts.
- out_data  output  NUM_OUT*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- out_cnt  output  NUM_OUT*CNT_W  lane i count at [i*CNT_W +: CNT_W]. Present only with DEMUX_COUNT_EN.

Behaviour:
- Reset (async assert, released synchronously to clk): every slot goes EMPTY; out_valid = 0; out_data = 0; out_cnt = 0.
- Per-lane FSM with two states, EMPTY and FULL:
  - EMPTY -> FULL on a push to that lane.
  - FULL -> EMPTY on a pop with no push in the same cycle.
  - FULL stays FULL on pop and push together; the slot reloads with the new word.
- Push: in_valid & in_ready. in_sel selects the lane.
- Pop on lane i: out_valid[i] & out_ready[i].
- in_ready = !full[in_sel] | out_ready[in_sel]. This is combinational from in_sel and out_ready, so a full lane can be refilled in the same cycle it drains. No combinational path exists from in_data to any output.
- Latency: a word pushed in cycle N is visible at lane in_sel from cycle N+1 (out_valid high, out_data = word).
- Producer rule: once in_valid is high, in_sel and in_data must be held until the push completes. Consumer rule: out_data[i] is stable while out_valid[i] is high and not popped.
- Lanes are independent. A push to lane A and pops on any other lanes in the same cycle all take effect.
- Full lane, no pop: in_ready = 0 for words addressed to that lane only. There is no head-of-line reordering; the blocked word stays at the input.
- in_valid = 0: in_ready still reflects the selected lane; no state changes.
- Reset mid-transfer discards all buffered words. No pop completes in the reset cycle.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- Defined:
  - Each lane has a CNT_W-bit counter that increments on every pop of that lane.
  - Counters wrap from 2^CNT_W-1 to 0 and reset to 0.
  - out_cnt exports the counters.
- Undefined: no counters and no out_cnt port. The handshake and data path are otherwise identical.

Decomposition:
- Package demux_pkg:
  - localparams DEMUX_WIDTH = 32, DEMUX_NUM_OUT = 4, DEMUX_SEL_W = 2.
  - Lane-state enum: SLOT_EMPTY, SLOT_FULL.
- Sub-module demux_slot: one-entry buffer with push, pop, data, full, and the optional counter. Instantiated NUM_OUT times in a generate loop.
- The top level holds only select decode and in_ready muxing.

Test Plan:
- Basic routing: after reset, push 32'hA0A0_0000 with sel = 0, 32'hB1B1_0001 with sel = 1, 32'hC2C2_0002 with sel = 2, 32'hD3D3_0003 with sel = 3, all out_ready = 1. Each word appears on its own lane exactly 1 cycle after its push; out_valid is one-hot per cycle.
- Backpressure isolation: out_ready[2] = 0; push 32'h1 with sel = 2, then 32'h2 with sel = 2, then 32'h3 with sel = 0. in_ready = 0 while 32'h2 waits. Lane 2 holds 32'h1. 32'h3 reaches lane 0 only after 32'h2 is accepted.
- Same-cycle pop and push: lane 1 FULL with 32'h11; raise out_ready[1] and push 32'h22 with sel = 1 in the same cycle. in_ready = 1; next cycle lane 1 = 32'h22 with out_valid[1] still high; no bubble.
- Async reset: lanes 0 and 3 full; assert rst mid-cycle. out_valid goes to 0 immediately, without waiting for a clk edge. After release, the first push behaves as in the basic routing test.
- Counter (DEMUX_COUNT_EN, CNT_W = 4): perform 17 pops on lane 3. Lane 3 count reads 1 (wrapped); the other lane counts read 0.
- Data hold: with out_ready[0] = 0, toggle in_data while in_valid = 0 for 5 cycles. Lane 0 data and valid are unchanged.
